// File: rtl/period_sequencer.sv
// period_sequencer: sequences a 0..period counter through a programmed
// number of laps. Optional hold input enabled by PERIOD_SEQ_PAUSE_EN.
module period_sequencer #(
    parameter int CNT_WIDTH = 8,
    parameter int REP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [REP_WIDTH-1:0] reps,
`ifdef PERIOD_SEQ_PAUSE_EN
    input  logic                 pause,
`endif
    output logic [CNT_WIDTH-1:0] count,
    output logic [REP_WIDTH-1:0] lap,
    output logic                 busy,
    output logic                 tick,
    output logic                 done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] period_r;
    logic [REP_WIDTH-1:0] reps_r;
    logic                 paused;
    logic                 wrap;
    logic                 last;

`ifdef PERIOD_SEQ_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign wrap = (count == period_r);
    assign last = (lap == reps_r - REP_WIDTH'(1));

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
        tick = (state == S_RUN) && !abort && !paused && wrap;
    end

    // Run control: latch configuration, advance count and laps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            count    <= '0;
            lap      <= '0;
            period_r <= '0;
            reps_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        period_r <= period;
                        reps_r   <= reps;
                        count    <= '0;
                        lap      <= '0;
                        state    <= (reps == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        count <= '0;
                        lap   <= '0;
                        state <= S_IDLE;
                    end else if (paused) begin
                        count <= count;
                    end else if (!wrap) begin
                        count <= count + CNT_WIDTH'(1);
                    end else begin
                        count <= '0;
                        if (last) begin
                            lap   <= reps_r;
                            state <= S_DONE;
                        end else begin
                            lap <= lap + REP_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_sequencer.sv
// tb_period_sequencer: scenario table, directed corner cases and random
// stimulus, all checked against a lap/offset arithmetic reference model.
module tb_period_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] period = '0;
    logic [3:0] reps = '0;
`ifdef PERIOD_SEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [7:0] count;
    logic [3:0] lap;
    logic       busy;
    logic       tick;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is described by elapsed run cycles m_k
    bit m_act = 0;
    int m_k = 0;
    int m_p = 0;
    int m_r = 0;
    int m_hc = 0;
    int m_hl = 0;

    typedef struct {
        int p;
        int r;
        int abort_at;
        int ticks;
        int done_at;
        int busy_len;
        int lap_end;
    } scn_t;

    scn_t tbl [5];

    period_sequencer #(.CNT_WIDTH(8), .REP_WIDTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .period  (period),
        .reps    (reps),
`ifdef PERIOD_SEQ_PAUSE_EN
        .pause   (pause),
`endif
        .count   (count),
        .lap     (lap),
        .busy    (busy),
        .tick    (tick),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // One clock cycle: drive, check at negedge, update model at posedge
    task automatic step(input bit st, input bit ab, input int pe,
                        input int re, input bit pz,
                        output bit o_tick, output bit o_done,
                        output bit o_busy);
        int tot;
        int ec;
        int el;
        bit eb;
        bit et;
        bit ed;
        logic [16:0] got;
        logic [16:0] want;
        start  = st;
        abort  = ab;
        period = pe[7:0];
        reps   = re[3:0];
`ifdef PERIOD_SEQ_PAUSE_EN
        pause  = pz;
`endif
        @(negedge clk);
        tot = m_r * (m_p + 1);
        if (!m_act) begin
            ec = m_hc; el = m_hl; eb = 0; et = 0; ed = 0;
        end else if (m_k < tot) begin
            ec = m_k % (m_p + 1);
            el = m_k / (m_p + 1);
            eb = 1; ed = 0;
            et = (ec == m_p) && !ab && !pz;
        end else begin
            ec = 0; el = m_r; eb = 1; et = 0; ed = 1;
        end
        got  = {count, lap, busy, tick, done};
        want = {ec[7:0], el[3:0], eb, et, ed};
        check("cycle", int'(got), int'(want));
        o_tick = tick;
        o_done = done;
        o_busy = busy;
        @(posedge clk);
        if (!m_act) begin
            if (st && !ab) begin
                m_act = 1; m_k = 0; m_p = pe; m_r = re;
            end
        end else if (m_k < tot) begin
            if (ab) begin
                m_act = 0; m_hc = 0; m_hl = 0;
            end else if (!pz) begin
                m_k++;
            end
        end else begin
            m_act = 0; m_hc = 0; m_hl = m_r;
        end
        #1;
    endtask

    task automatic run_scn(input int idx);
        scn_t s;
        bit t;
        bit d;
        bit b;
        int nt;
        int dat;
        int bl;
        int lim;
        s = tbl[idx];
        nt = 0; dat = -1; bl = 0;
        lim = s.r * (s.p + 1) + 6;
        step(1, 0, s.p, s.r, 0, t, d, b);
        for (int i = 0; i < lim; i++) begin
            step(0, i == s.abort_at, s.p, s.r, 0, t, d, b);
            if (t) nt++;
            if (d && dat < 0) dat = i;
            if (b) bl++;
        end
        check($sformatf("scn%0d_ticks", idx), nt, s.ticks);
        check($sformatf("scn%0d_done", idx), dat, s.done_at);
        check($sformatf("scn%0d_busy", idx), bl, s.busy_len);
        check($sformatf("scn%0d_lap", idx), int'(lap), s.lap_end);
        check($sformatf("scn%0d_count", idx), int'(count), 0);
    endtask

    initial begin
        bit t;
        bit d;
        bit b;
        int dat;
        tbl[0] = '{p: 3,   r: 2, abort_at: -1, ticks: 2,
                   done_at: 8,   busy_len: 9,   lap_end: 2};
        tbl[1] = '{p: 0,   r: 3, abort_at: -1, ticks: 3,
                   done_at: 3,   busy_len: 4,   lap_end: 3};
        tbl[2] = '{p: 5,   r: 0, abort_at: -1, ticks: 0,
                   done_at: 0,   busy_len: 1,   lap_end: 0};
        tbl[3] = '{p: 4,   r: 2, abort_at: 2,  ticks: 0,
                   done_at: -1,  busy_len: 3,   lap_end: 0};
        tbl[4] = '{p: 255, r: 1, abort_at: -1, ticks: 1,
                   done_at: 256, busy_len: 257, lap_end: 1};

        #3;
        check("reset_outputs", int'({count, lap, busy, tick, done}), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 0, 0, 0, t, d, b);

        for (int i = 0; i < 5; i++) run_scn(i);

        // start together with abort in IDLE is rejected
        step(1, 1, 3, 2, 0, t, d, b);
        step(0, 0, 3, 2, 0, t, d, b);
        check("start_abort_busy", int'(b), 0);

        // start and config changes while busy are ignored
        dat = -1;
        step(1, 0, 2, 2, 0, t, d, b);
        for (int i = 0; i < 10; i++) begin
            step(i == 2, 0, (i >= 2) ? 7 : 2, (i >= 2) ? 9 : 2,
                 0, t, d, b);
            if (d && dat < 0) dat = i;
        end
        check("busy_start_done", dat, 6);
        check("busy_start_lap", int'(lap), 2);

        // asynchronous reset in the middle of a run
        step(1, 0, 6, 3, 0, t, d, b);
        repeat (5) step(0, 0, 6, 3, 0, t, d, b);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset", int'({count, lap, busy, tick, done}), 0);
        m_act = 0; m_hc = 0; m_hl = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step(0, 0, 6, 3, 0, t, d, b);
        check("after_reset_done", int'(d), 0);

`ifdef PERIOD_SEQ_PAUSE_EN
        // pause for three cycles at count 1 delays done by three
        dat = -1;
        step(1, 0, 2, 1, 0, t, d, b);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2, 1, (i >= 1 && i <= 3), t, d, b);
            if (d && dat < 0) dat = i;
        end
        check("pause_done", dat, 6);
`endif

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit rs;
            bit ra;
            bit rz;
            int rp;
            int rr;
            rs = ($urandom_range(0, 7) == 0);
            ra = ($urandom_range(0, 39) == 0);
`ifdef PERIOD_SEQ_PAUSE_EN
            rz = ($urandom_range(0, 5) == 0);
`else
            rz = 0;
`endif
            rp = ($urandom_range(0, 15) == 0) ?
                 int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
            rr = (rp > 7) ? int'($urandom_range(0, 2))
                          : int'($urandom_range(0, 4));
            step(rs, ra, rp, rr, rz, t, d, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
